// File: rtl/axis_tu_pkg.sv
// Shared types, LFSR tap table and pattern stepping for the AXI-stream test unit.
package axis_tu_pkg;

   typedef enum logic {
      TU_INCR = 1'b0,
      TU_PRBS = 1'b1
   } tu_mode_e;

   typedef enum logic [1:0] {
      GEN_IDLE = 2'd0,
      GEN_SEND = 2'd1,
      GEN_GAP  = 2'd2,
      GEN_DONE = 2'd3
   } gen_state_e;

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Mask selecting the low w bits of a 32-bit word.
   function automatic logic [31:0] width_mask(int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   // Maximal-length Fibonacci feedback taps, bit i set = stage i+1 tapped.
   function automatic logic [31:0] lfsr_taps(int w);
      case (w)
         2:       return 32'h0000_0003;
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         17:      return 32'h0001_2000;
         18:      return 32'h0002_0400;
         19:      return 32'h0004_0023;
         20:      return 32'h0009_0000;
         21:      return 32'h0014_0000;
         22:      return 32'h0030_0000;
         23:      return 32'h0042_0000;
         24:      return 32'h00E1_0000;
         25:      return 32'h0120_0000;
         26:      return 32'h0200_0023;
         27:      return 32'h0400_0013;
         28:      return 32'h0900_0000;
         29:      return 32'h1400_0000;
         30:      return 32'h2000_0029;
         31:      return 32'h4800_0000;
         32:      return 32'h8020_0003;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // Value the pattern register holds after reset.
   function automatic logic [31:0] seed_pattern(tu_mode_e mode, int w);
      return (mode == TU_PRBS) ? width_mask(w) : 32'd0;
   endfunction

   // One step of the pattern sequence for a w-bit register.
   function automatic logic [31:0] next_pattern(tu_mode_e mode, logic [31:0] value, int w);
      logic fb;
      if (mode == TU_INCR) begin
         return (value + 32'd1) & width_mask(w);
      end
      fb = ^(value & lfsr_taps(w));
      return ((value << 1) | {31'd0, fb}) & width_mask(w);
   endfunction

endpackage

// File: rtl/axi_stream_inf.sv
// AXI-stream bundle. A beat transfers on a rising clock edge where tvalid and
// tready are both 1; once tvalid is raised the master holds tdata/tuser/tlast
// stable and keeps tvalid high until that transfer happens.
interface axi_stream_inf #(
   parameter int DSIZE = 8,
   parameter int USIZE = 1
) ();
   logic             tvalid;
   logic             tready;
   logic [DSIZE-1:0] tdata;
   logic [USIZE-1:0] tuser;
   logic             tlast;

   modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
   modport slaver (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_tu_pattern.sv
// Pattern register: seeded on reset, steps once per advance strobe.
module axis_tu_pattern
   import axis_tu_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int MODE  = 0
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             advance,
   output logic [DSIZE-1:0] value
);

   localparam tu_mode_e         PMODE = (MODE == 1) ? TU_PRBS : TU_INCR;
   localparam logic [DSIZE-1:0] SEED  = DSIZE'(seed_pattern(PMODE, DSIZE));

   // Hold the current pattern word; step it only on an accepted beat.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         value <= SEED;
      end else if (advance) begin
         value <= DSIZE'(next_pattern(PMODE, 32'(value), DSIZE));
      end
   end

endmodule

// File: rtl/axis_test_unit_gen_chk.sv
// AXI-stream test unit: packet generator on axis_out, independent checker on axis_in.
module axis_test_unit_gen_chk
   import axis_tu_pkg::*;
#(
   parameter int DSIZE    = 8,
   parameter int USIZE    = 1,
   parameter int PKT_LEN  = 16,
   parameter int MODE     = 0,
   parameter int GAP      = 2,
   parameter int NUM_PKTS = 0,
   parameter int RDY_MODE = 0
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              enable,
   axi_stream_inf.master     axis_out,
   axi_stream_inf.slaver     axis_in,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              err_flag,
   output gen_state_e        dbg_gen_state
);

   localparam int               BW         = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BW-1:0]    LAST_BEAT  = BW'(PKT_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] NUM_PKTS_C = CNT_W'(NUM_PKTS);

   gen_state_e       state_q, state_d;
   logic [BW-1:0]    gen_beat, chk_beat;
   logic [CNT_W-1:0] gap_cnt, sent_cnt;
   logic [DSIZE-1:0] gen_value, chk_value;
   logic             gen_accept, gen_last, gen_final;
   logic             chk_accept, exp_sof, exp_last, beat_err;
   logic [1:0]       rdy_cnt;
   logic             rdy_en;

   assign gen_accept = axis_out.tvalid && axis_out.tready;
   assign gen_last   = (gen_beat == LAST_BEAT);
   assign gen_final  = (NUM_PKTS != 0) && (sent_cnt == NUM_PKTS_C - 1'b1);

   axis_tu_pattern #(.DSIZE(DSIZE), .MODE(MODE)) u_gen_pattern (
      .clock   (clock),
      .rst_n   (rst_n),
      .advance (gen_accept),
      .value   (gen_value)
   );

   axis_tu_pattern #(.DSIZE(DSIZE), .MODE(MODE)) u_chk_pattern (
      .clock   (clock),
      .rst_n   (rst_n),
      .advance (chk_accept),
      .value   (chk_value)
   );

   // Generator state register.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state_q <= GEN_IDLE;
      else        state_q <= state_d;
   end

   // Generator next state: packets always finish before stopping.
   always_comb begin
      state_d = state_q;
      case (state_q)
         GEN_IDLE: if (enable) state_d = GEN_SEND;
         GEN_SEND: begin
            if (gen_accept && gen_last) begin
               if (gen_final)     state_d = GEN_DONE;
               else if (!enable)  state_d = GEN_IDLE;
               else if (GAP == 0) state_d = GEN_SEND;
               else               state_d = GEN_GAP;
            end
         end
         GEN_GAP: begin
            if (!enable)                  state_d = GEN_IDLE;
            else if (gap_cnt == GAP_LAST) state_d = GEN_SEND;
         end
         GEN_DONE: state_d = GEN_DONE;
         default:  state_d = GEN_IDLE;
      endcase
   end

   // Generator outputs and status; beat fields are zero whenever tvalid is low.
   always_comb begin
      axis_out.tvalid    = (state_q == GEN_SEND);
      axis_out.tdata     = axis_out.tvalid ? gen_value : '0;
      axis_out.tuser     = '0;
      axis_out.tuser[0]  = axis_out.tvalid && (gen_beat == '0);
      axis_out.tlast     = axis_out.tvalid && gen_last;
      busy               = (state_q == GEN_SEND) || (state_q == GEN_GAP) || (chk_beat != '0);
      dbg_gen_state      = state_q;
   end

   // Generator beat index, gap timer and sent-packet count.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         gen_beat <= '0;
         gap_cnt  <= '0;
         sent_cnt <= '0;
      end else begin
         if (gen_accept) begin
            gen_beat <= gen_last ? '0 : gen_beat + 1'b1;
            if (gen_last && sent_cnt != CNT_MAX) sent_cnt <= sent_cnt + 1'b1;
         end
         gap_cnt <= (state_q == GEN_GAP) ? gap_cnt + 1'b1 : '0;
      end
   end

   // Checker ready: high from the first cycle out of reset, optionally 1-in-4 low.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rdy_cnt <= '0;
         rdy_en  <= 1'b0;
      end else begin
         rdy_cnt <= rdy_cnt + 1'b1;
         rdy_en  <= 1'b1;
      end
   end

   assign axis_in.tready = rdy_en && ((RDY_MODE == 0) || (rdy_cnt != 2'd3));
   assign chk_accept     = axis_in.tvalid && axis_in.tready;
   assign exp_sof        = (chk_beat == '0);
   assign exp_last       = (chk_beat == LAST_BEAT);
   assign beat_err       = chk_accept && ((axis_in.tdata != chk_value) ||
                                          (axis_in.tuser[0] != exp_sof) ||
                                          (axis_in.tlast != exp_last));

   // Checker beat index and saturating packet/error counters; no resync on error.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         chk_beat <= '0;
         pkt_cnt  <= '0;
         err_cnt  <= '0;
         err_flag <= 1'b0;
      end else if (chk_accept) begin
         chk_beat <= (axis_in.tlast || exp_last) ? '0 : chk_beat + 1'b1;
         if (axis_in.tlast && pkt_cnt != CNT_MAX) pkt_cnt <= pkt_cnt + 1'b1;
         if (beat_err) begin
            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
            err_flag <= 1'b1;
         end
      end
   end

   // Run complete once every generated packet has been received.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) done <= 1'b0;
      else        done <= done | ((NUM_PKTS != 0) && (state_q == GEN_DONE) && (pkt_cnt == NUM_PKTS_C));
   end

endmodule

// File: tb/tb_axis_test_unit_gen_chk.sv
// Bench for axis_test_unit_gen_chk: four looped-back instances with different parameters.
module tb_axis_test_unit_gen_chk;
   import axis_tu_pkg::*;

   // clock / reset
   logic clock = 1'b0;
   logic rst_n = 1'b0;
   always #5 clock = ~clock;

   logic       en_a = 1'b0, en_b = 1'b0, en_c = 1'b0, en_d = 1'b0;
   logic [7:0] flip_c = 8'h00;
   int         total = 0;
   int         bad = 0;

   logic        busy_a, done_a, eflag_a, busy_b, done_b, eflag_b;
   logic        busy_c, done_c, eflag_c, busy_d, done_d, eflag_d;
   logic [15:0] pkt_a, err_a, pkt_b, err_b, pkt_c, err_c, pkt_d, err_d;
   gen_state_e  st_a, st_b, st_c, st_d;

   axi_stream_inf #(.DSIZE(8), .USIZE(1)) a_out ();
   axi_stream_inf #(.DSIZE(8), .USIZE(1)) a_in ();
   axi_stream_inf #(.DSIZE(8), .USIZE(1)) b_out ();
   axi_stream_inf #(.DSIZE(8), .USIZE(1)) b_in ();
   axi_stream_inf #(.DSIZE(8), .USIZE(1)) c_out ();
   axi_stream_inf #(.DSIZE(8), .USIZE(1)) c_in ();
   axi_stream_inf #(.DSIZE(8), .USIZE(1)) d_out ();
   axi_stream_inf #(.DSIZE(8), .USIZE(1)) d_in ();

   // Loopback wiring; instance C can have tdata bits flipped on the way back.
   assign a_in.tvalid = a_out.tvalid; assign a_in.tdata = a_out.tdata;
   assign a_in.tuser  = a_out.tuser;  assign a_in.tlast = a_out.tlast;
   assign a_out.tready = a_in.tready;
   assign b_in.tvalid = b_out.tvalid; assign b_in.tdata = b_out.tdata;
   assign b_in.tuser  = b_out.tuser;  assign b_in.tlast = b_out.tlast;
   assign b_out.tready = b_in.tready;
   assign c_in.tvalid = c_out.tvalid; assign c_in.tdata = c_out.tdata ^ flip_c;
   assign c_in.tuser  = c_out.tuser;  assign c_in.tlast = c_out.tlast;
   assign c_out.tready = c_in.tready;
   assign d_in.tvalid = d_out.tvalid; assign d_in.tdata = d_out.tdata;
   assign d_in.tuser  = d_out.tuser;  assign d_in.tlast = d_out.tlast;
   assign d_out.tready = d_in.tready;

   axis_test_unit_gen_chk #(.DSIZE(8), .USIZE(1), .PKT_LEN(4), .MODE(0), .GAP(2), .NUM_PKTS(3), .RDY_MODE(0)) dut_a (
      .clock(clock), .rst_n(rst_n), .enable(en_a), .axis_out(a_out), .axis_in(a_in), .busy(busy_a),
      .done(done_a), .pkt_cnt(pkt_a), .err_cnt(err_a), .err_flag(eflag_a), .dbg_gen_state(st_a));
   axis_test_unit_gen_chk #(.DSIZE(8), .USIZE(1), .PKT_LEN(4), .MODE(0), .GAP(0), .NUM_PKTS(80), .RDY_MODE(0)) dut_b (
      .clock(clock), .rst_n(rst_n), .enable(en_b), .axis_out(b_out), .axis_in(b_in), .busy(busy_b),
      .done(done_b), .pkt_cnt(pkt_b), .err_cnt(err_b), .err_flag(eflag_b), .dbg_gen_state(st_b));
   axis_test_unit_gen_chk #(.DSIZE(8), .USIZE(1), .PKT_LEN(5), .MODE(1), .GAP(1), .NUM_PKTS(6), .RDY_MODE(1)) dut_c (
      .clock(clock), .rst_n(rst_n), .enable(en_c), .axis_out(c_out), .axis_in(c_in), .busy(busy_c),
      .done(done_c), .pkt_cnt(pkt_c), .err_cnt(err_c), .err_flag(eflag_c), .dbg_gen_state(st_c));
   axis_test_unit_gen_chk #(.DSIZE(8), .USIZE(1), .PKT_LEN(8), .MODE(0), .GAP(2), .NUM_PKTS(0), .RDY_MODE(0)) dut_d (
      .clock(clock), .rst_n(rst_n), .enable(en_d), .axis_out(d_out), .axis_in(d_in), .busy(busy_d),
      .done(done_d), .pkt_cnt(pkt_d), .err_cnt(err_d), .err_flag(eflag_d), .dbg_gen_state(st_d));

   // Reference pattern: counter mod 256, or x^8+x^6+x^5+x^4+1 shift-left LFSR.
   function automatic logic [7:0] model_next(bit prbs, logic [7:0] v);
      if (!prbs) return v + 8'd1;
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   task automatic apply_reset();
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0; flip_c = 8'h00;
      @(negedge clock); rst_n = 1'b0;
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clock);
      total++; if ({a_out.tvalid, a_out.tlast, a_out.tuser, a_out.tdata} !== 11'd0) begin bad++;
         $display("FAIL reset_out_a: got %h want 0", {a_out.tvalid, a_out.tlast, a_out.tuser, a_out.tdata}); end
      total++; if ({c_out.tvalid, c_out.tdata} !== 9'd0) begin bad++;
         $display("FAIL reset_out_c: got %h want 0", {c_out.tvalid, c_out.tdata}); end
      total++; if (a_in.tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b want 0", a_in.tready); end
      total++; if ({busy_a, done_a, eflag_a, pkt_a, err_a} !== 35'd0) begin bad++;
         $display("FAIL reset_status: got %h want 0", {busy_a, done_a, eflag_a, pkt_a, err_a}); end
      rst_n = 1'b1;
      @(negedge clock);
      total++; if (a_in.tready !== 1'b1) begin bad++; $display("FAIL reset_tready_release: got %b want 1", a_in.tready); end
   endtask

   task automatic test_loopback_incr();
      logic [7:0] exp_q[$];
      logic [7:0] v;
      logic [7:0] exp_d;
      int beats = 0, idle = 0, early = 0;
      apply_reset();
      v = 8'h00;
      for (int i = 0; i < 12; i++) begin exp_q.push_back(v); v = model_next(1'b0, v); end
      en_a = 1'b1;
      for (int cyc = 0; cyc < 200 && done_a !== 1'b1; cyc++) begin
         @(negedge clock);
         if (done_a === 1'b1 && beats != 12) early++;
         if (a_out.tvalid && a_out.tready) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            total++;
            if (a_out.tdata !== exp_d || a_out.tuser[0] !== (beats % 4 == 0) || a_out.tlast !== (beats % 4 == 3)) begin
               bad++; $display("FAIL loop_beat%0d: data/sof/last=%h/%b/%b want %h/%b/%b", beats, a_out.tdata,
                  a_out.tuser[0], a_out.tlast, exp_d, (beats % 4 == 0), (beats % 4 == 3));
            end
            if (beats == 0) begin
               total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL loop_busy: got %b want 1", busy_a); end
            end
            beats++;
         end else if (beats > 0 && beats < 12) idle++;
      end
      total++; if (beats != 12) begin bad++; $display("FAIL loop_beats: got %0d want 12", beats); end
      total++; if (idle != 4) begin bad++; $display("FAIL loop_gap_cycles: got %0d want 4", idle); end
      total++; if (done_a !== 1'b1 || early != 0) begin bad++; $display("FAIL loop_done: got %b early=%0d want 1 early=0", done_a, early); end
      total++; if (pkt_a !== 16'd3) begin bad++; $display("FAIL loop_pkt_cnt: got %0d want 3", pkt_a); end
      total++; if (err_a !== 16'd0 || eflag_a !== 1'b0) begin bad++; $display("FAIL loop_err: got %0d/%b want 0/0", err_a, eflag_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL loop_idle_busy: got %b want 0", busy_a); end
      en_a = 1'b0;
   endtask

   task automatic test_wrap();
      logic [7:0] v = 8'h00;
      logic [7:0] prev = 8'h00;
      int beats = 0, idle = 0, wrapped = 0;
      apply_reset();
      en_b = 1'b1;
      for (int cyc = 0; cyc < 1000 && done_b !== 1'b1; cyc++) begin
         @(negedge clock);
         if (b_out.tvalid && b_out.tready) begin
            total++;
            if (b_out.tdata !== v || b_out.tlast !== (beats % 4 == 3)) begin
               bad++; $display("FAIL wrap_beat%0d: data/last=%h/%b want %h/%b", beats, b_out.tdata, b_out.tlast, v, (beats % 4 == 3));
            end
            if (beats > 0 && prev == 8'hFF && b_out.tdata == 8'h00) wrapped++;
            prev = b_out.tdata;
            v = model_next(1'b0, v);
            beats++;
         end else if (beats > 0 && beats < 320) idle++;
      end
      total++; if (beats != 320) begin bad++; $display("FAIL wrap_beats: got %0d want 320", beats); end
      total++; if (wrapped != 1) begin bad++; $display("FAIL wrap_seen: got %0d want 1", wrapped); end
      total++; if (idle != 0) begin bad++; $display("FAIL wrap_back_to_back: got %0d idle want 0", idle); end
      total++; if (pkt_b !== 16'd80 || done_b !== 1'b1) begin bad++; $display("FAIL wrap_pkt_done: got %0d/%b want 80/1", pkt_b, done_b); end
      total++; if (err_b !== 16'd0) begin bad++; $display("FAIL wrap_err: got %0d want 0", err_b); end
   endtask

   task automatic test_prbs_backpressure();
      logic [7:0] exp_q[$];
      logic [7:0] v;
      logic [7:0] exp_d;
      logic [9:0] held_bits = '0;
      logic       held = 1'b0;
      int beats = 0, stalls = 0;
      apply_reset();
      v = 8'hFF;
      for (int i = 0; i < 30; i++) begin exp_q.push_back(v); v = model_next(1'b1, v); end
      en_c = 1'b1;
      for (int cyc = 0; cyc < 400 && done_c !== 1'b1; cyc++) begin
         @(negedge clock);
         if (held) begin
            total++;
            if ({c_out.tvalid, c_out.tdata, c_out.tuser[0], c_out.tlast} !== {1'b1, held_bits}) begin
               bad++; $display("FAIL prbs_hold: got %h want %h", {c_out.tvalid, c_out.tdata, c_out.tuser[0], c_out.tlast}, {1'b1, held_bits});
            end
         end
         held = c_out.tvalid && !c_out.tready;
         held_bits = {c_out.tdata, c_out.tuser[0], c_out.tlast};
         if (held) stalls++;
         if (c_out.tvalid && c_out.tready) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            total++;
            if (c_out.tdata !== exp_d || c_out.tuser[0] !== (beats % 5 == 0) || c_out.tlast !== (beats % 5 == 4)) begin
               bad++; $display("FAIL prbs_beat%0d: data/sof/last=%h/%b/%b want %h/%b/%b", beats, c_out.tdata,
                  c_out.tuser[0], c_out.tlast, exp_d, (beats % 5 == 0), (beats % 5 == 4));
            end
            beats++;
         end
      end
      total++; if (beats != 30) begin bad++; $display("FAIL prbs_beats: got %0d want 30", beats); end
      total++; if (stalls == 0) begin bad++; $display("FAIL prbs_stalls: got %0d want >0", stalls); end
      total++; if (pkt_c !== 16'd6 || done_c !== 1'b1) begin bad++; $display("FAIL prbs_pkt_done: got %0d/%b want 6/1", pkt_c, done_c); end
      total++; if (err_c !== 16'd0 || eflag_c !== 1'b0) begin bad++; $display("FAIL prbs_err: got %0d/%b want 0/0", err_c, eflag_c); end
   endtask

   task automatic test_error_inject();
      int n = 0;
      bit pre_done = 0, post_done = 0;
      apply_reset();
      en_c = 1'b1;
      for (int cyc = 0; cyc < 400 && done_c !== 1'b1; cyc++) begin
         @(negedge clock);
         if (n == 7 && !pre_done) begin
            pre_done = 1;
            total++; if (err_c !== 16'd0) begin bad++; $display("FAIL inject_before: got %0d want 0", err_c); end
         end
         if (n == 8 && !post_done) begin
            post_done = 1;
            total++; if (err_c !== 16'd1 || eflag_c !== 1'b1) begin bad++; $display("FAIL inject_after: got %0d/%b want 1/1", err_c, eflag_c); end
         end
         flip_c = (n == 7) ? 8'h01 : 8'h00;
         if (c_out.tvalid && c_out.tready) n++;
      end
      flip_c = 8'h00;
      total++; if (err_c !== 16'd1 || eflag_c !== 1'b1) begin bad++; $display("FAIL inject_final_err: got %0d/%b want 1/1", err_c, eflag_c); end
      total++; if (pkt_c !== 16'd6 || done_c !== 1'b1) begin bad++; $display("FAIL inject_pkt_done: got %0d/%b want 6/1", pkt_c, done_c); end
   endtask

   task automatic test_enable_drop();
      logic [7:0] v = 8'h00;
      int n = 0;
      apply_reset();
      en_d = 1'b1;
      for (int cyc = 0; cyc < 140; cyc++) begin
         @(negedge clock);
         if (cyc == 59) begin
            total++; if (n != 8 || st_d !== GEN_IDLE || d_out.tvalid !== 1'b0 || busy_d !== 1'b0 || pkt_d !== 16'd1) begin
               bad++; $display("FAIL drop_idle: beats=%0d state=%0d tvalid=%b busy=%b pkts=%0d want 8/0/0/0/1",
                  n, st_d, d_out.tvalid, busy_d, pkt_d);
            end
         end
         if (cyc == 60) en_d = 1'b1;
         if (n == 1 || n == 9) en_d = 1'b0;
         if (d_out.tvalid && d_out.tready) begin
            total++;
            if (d_out.tdata !== v || d_out.tuser[0] !== (n % 8 == 0) || d_out.tlast !== (n % 8 == 7)) begin
               bad++; $display("FAIL drop_beat%0d: data/sof/last=%h/%b/%b want %h/%b/%b", n, d_out.tdata,
                  d_out.tuser[0], d_out.tlast, v, (n % 8 == 0), (n % 8 == 7));
            end
            v = model_next(1'b0, v);
            n++;
         end
      end
      total++; if (n != 16) begin bad++; $display("FAIL drop_total_beats: got %0d want 16", n); end
      total++; if (pkt_d !== 16'd2 || err_d !== 16'd0) begin bad++; $display("FAIL drop_counts: got %0d/%0d want 2/0", pkt_d, err_d); end
   endtask

   task automatic test_random_enable();
      logic [7:0] v = 8'h00;
      int n = 0;
      apply_reset();
      for (int cyc = 0; cyc < 440; cyc++) begin
         @(negedge clock);
         en_d = (cyc < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
         if (d_out.tvalid && d_out.tready) begin
            total++;
            if (d_out.tdata !== v || d_out.tuser[0] !== (n % 8 == 0) || d_out.tlast !== (n % 8 == 7)) begin
               bad++; $display("FAIL rand_beat%0d: data/sof/last=%h/%b/%b want %h/%b/%b", n, d_out.tdata,
                  d_out.tuser[0], d_out.tlast, v, (n % 8 == 0), (n % 8 == 7));
            end
            v = model_next(1'b0, v);
            n++;
         end
      end
      total++; if (n == 0 || n % 8 != 0) begin bad++; $display("FAIL rand_whole_packets: got %0d beats want nonzero multiple of 8", n); end
      total++; if (pkt_d !== 16'(n / 8)) begin bad++; $display("FAIL rand_pkt_cnt: got %0d want %0d", pkt_d, n / 8); end
      total++; if (err_d !== 16'd0 || busy_d !== 1'b0) begin bad++; $display("FAIL rand_err_busy: got %0d/%b want 0/0", err_d, busy_d); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int target;
      bit got = 0;
      apply_reset();
      target = $urandom_range(10, 13);
      en_d = 1'b1;
      for (int cyc = 0; cyc < 100 && n < target; cyc++) begin
         @(negedge clock);
         if (d_out.tvalid && d_out.tready) n++;
      end
      total++; if (n != target || pkt_d !== 16'd1 || d_out.tvalid !== 1'b1) begin
         bad++; $display("FAIL rstmid_setup: beats=%0d pkts=%0d tvalid=%b want %0d/1/1", n, pkt_d, d_out.tvalid, target); end
      rst_n = 1'b0;
      #1;
      total++; if ({d_out.tvalid, d_out.tlast, d_out.tdata, d_in.tready} !== 11'd0) begin
         bad++; $display("FAIL rstmid_stream: got %h want 0", {d_out.tvalid, d_out.tlast, d_out.tdata, d_in.tready}); end
      total++; if ({pkt_d, err_d, busy_d} !== 33'd0) begin bad++; $display("FAIL rstmid_counters: got %h want 0", {pkt_d, err_d, busy_d}); end
      @(negedge clock);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 20 && !got; cyc++) begin
         @(negedge clock);
         if (d_out.tvalid && d_out.tready) begin
            got = 1;
            total++; if (d_out.tdata !== 8'h00 || d_out.tuser[0] !== 1'b1) begin
               bad++; $display("FAIL rstmid_restart: data/sof=%h/%b want 00/1", d_out.tdata, d_out.tuser[0]); end
         end
      end
      total++; if (!got) begin bad++; $display("FAIL rstmid_timeout: got no beat want one within 20 cycles"); end
      en_d = 1'b0;
   endtask

   initial begin
      test_reset();
      test_loopback_incr();
      test_wrap();
      test_prbs_backpressure();
      test_error_inject();
      test_enable_drop();
      test_random_enable();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
